// File: rtl/stream_mux_rr.sv
// N-channel stream mux, indexed or round-robin selection, one registered output stage.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle while out_ready=1.
// Backpressure: in_ready is all 0 while a word is held and out_ready=0.
module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int W     = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  input  logic              out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] scan;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             load;
  logic             xfer;
  logic [W-1:0]     grant_data;

  // The output stage takes a new word when empty or drained this cycle.
  assign load = ~out_valid | out_ready;

  // Round-robin scan starting just after the last granted channel.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    scan     = ptr;
    for (int k = 0; k < N_CH; k++) begin
      scan = (scan == SEL_W'(N_CH - 1)) ? '0 : scan + 1'b1;
      if (!rr_found && in_valid[scan]) begin
        rr_found = 1'b1;
        rr_grant = scan;
      end
    end
  end

  // Pick the candidate channel for this cycle; out-of-range sel grants nothing.
  always_comb begin
    if (mode) begin
      grant    = rr_grant;
      grant_ok = rr_found;
    end else begin
      grant    = sel;
      grant_ok = (int'(sel) < N_CH);
    end
  end

  // One-hot ready and data selection for the granted channel.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = load & grant_ok;
        grant_data  = in_data[i*W +: W];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Output register and arbiter pointer; pointer moves only on round-robin transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SEL_W'(N_CH - 1);
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer && mode) begin
        ptr <= grant;
      end
    end
  end

endmodule
